// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-wide I2C master between NREQ clients.
// Latches the winner, pulses newd, waits for done (with timeout) and returns the result.
module i2c_txn_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              newd,
  output logic              wr,
  output logic [6:0]        addr,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  input  logic              done
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   sel;
  logic [CW-1:0]   cnt;

  logic [SW-1:0]   win;
  logic [SW-1:0]   win_next_ptr;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] sel_oh;
  logic            win_wr;
  logic [6:0]      win_addr;
  logic [7:0]      win_wdata;

  // Winner = lowest set bit at or above rr_ptr; failing that, lowest set bit overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = SW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(rr_ptr))) win = SW'(i);
    end
  end

  // Field mux and one-hot decodes, written as loops so every index is a constant.
  always_comb begin
    win_next_ptr = '0;
    win_oh       = '0;
    sel_oh       = '0;
    win_wr       = 1'b0;
    win_addr     = '0;
    win_wdata    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == SW'(i)) begin
        win_oh[i]    = 1'b1;
        win_wr       = req_wr[i];
        win_addr     = req_addr[7*i +: 7];
        win_wdata    = req_wdata[8*i +: 8];
        win_next_ptr = SW'((i + 1) % NREQ);
      end
      if (sel == SW'(i)) sel_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the latched master fields are reset as well because they are visible outputs.
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      newd      <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignment; pulse outputs default low each cycle.
      gnt       <= '0;
      rsp_valid <= '0;
      newd      <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            wr     <= win_wr;
            addr   <= win_addr;
            wdata  <= win_wdata;
            sel    <= win;
            rr_ptr <= win_next_ptr;
            gnt    <= win_oh;
            newd   <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // done has priority over a timeout landing on the same cycle.
          if (done) begin
            rsp_rdata <= wr ? 8'h00 : rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= sel_oh;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
            rsp_valid <= sel_oh;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: one instance with the default timeout,
// one with TIMEOUT_CYC=16 for the timeout and done/timeout-coincidence cases.
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  a_req, a_req_wr, a_gnt, a_rsp_valid;
  logic [13:0] a_req_addr;
  logic [15:0] a_req_wdata;
  logic [7:0]  a_rsp_rdata, a_wdata, a_rdata;
  logic        a_rsp_err, a_busy, a_newd, a_wr, a_done;
  logic [6:0]  a_addr;

  logic [1:0]  b_req, b_req_wr, b_gnt, b_rsp_valid;
  logic [13:0] b_req_addr;
  logic [15:0] b_req_wdata;
  logic [7:0]  b_rsp_rdata, b_wdata, b_rdata;
  logic        b_rsp_err, b_busy, b_newd, b_wr, b_done;
  logic [6:0]  b_addr;

  int n_checks   = 0;
  int n_fail     = 0;
  int a_newd_cnt = 0;

  i2c_txn_arbiter #(.NREQ(2), .TIMEOUT_CYC(4096)) dut_a (
    .clk(clk), .rst(rst),
    .req(a_req), .req_wr(a_req_wr), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .gnt(a_gnt), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy), .newd(a_newd), .wr(a_wr), .addr(a_addr), .wdata(a_wdata),
    .rdata(a_rdata), .done(a_done)
  );

  i2c_txn_arbiter #(.NREQ(2), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst),
    .req(b_req), .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .gnt(b_gnt), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy), .newd(b_newd), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .done(b_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_newd) a_newd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         n;
    int         newd_base;
    logic [1:0] exp_g;

    a_req = '0; a_req_wr = '0; a_req_addr = '0; a_req_wdata = '0; a_rdata = '0; a_done = 1'b0;
    b_req = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0; b_rdata = '0; b_done = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_a_outputs", {a_gnt, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy, a_newd, a_wr, a_addr, a_wdata}, 0);
    check("rst_b_outputs", {b_gnt, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_busy, b_newd, b_wr, b_addr, b_wdata}, 0);
    rst = 1'b0;
    tick();

    // Requester 0 write 0x12 <- 0xA5, done 20 cycles after newd
    a_req_wr = 2'b01; a_req_addr = {7'h00, 7'h12}; a_req_wdata = {8'h00, 8'hA5}; a_req = 2'b01;
    tick();
    check("t1_gnt", a_gnt, 2'b01);
    check("t1_newd", a_newd, 1);
    check("t1_busy", a_busy, 1);
    check("t1_latch", {a_wr, a_addr, a_wdata}, {1'b1, 7'h12, 8'hA5});
    a_req = '0; a_req_wr = '0; a_req_addr = '0; a_req_wdata = '0;
    for (int i = 0; i < 19; i++) begin
      tick();
      check("t1_hold", {a_wr, a_addr, a_wdata}, {1'b1, 7'h12, 8'hA5});
      check("t1_quiet", {a_gnt, a_newd, a_rsp_valid}, 0);
    end
    a_rdata = 8'hFF; a_done = 1'b1;
    tick();
    a_done = 1'b0; a_rdata = 8'h00;
    check("t1_rsp_valid", a_rsp_valid, 2'b01);
    check("t1_rsp_rdata", a_rsp_rdata, 8'h00);
    check("t1_rsp_err", a_rsp_err, 0);
    tick();
    check("t1_idle", {a_rsp_valid, a_busy}, 0);

    // Requester 1 read 0x12, master returns 0xA5
    newd_base = a_newd_cnt;
    a_req_wr = 2'b00; a_req_addr = {7'h12, 7'h00}; a_req = 2'b10;
    tick();
    check("t2_gnt", a_gnt, 2'b10);
    check("t2_latch", {a_newd, a_wr, a_addr}, {1'b1, 1'b0, 7'h12});
    a_req = '0;
    tick(); tick(); tick();
    a_rdata = 8'hA5; a_done = 1'b1;
    tick();
    a_done = 1'b0; a_rdata = 8'h00;
    check("t2_rsp_valid", a_rsp_valid, 2'b10);
    check("t2_rsp_rdata", a_rsp_rdata, 8'hA5);
    check("t2_rsp_err", a_rsp_err, 0);
    tick();
    check("t2_newd_pulses", a_newd_cnt - newd_base, 1);
    check("t2_rdata_hold", {a_rsp_valid, a_rsp_rdata}, {2'b00, 8'hA5});

    // Both requesters hold req from reset: grants 0,1,0,1 with no overlap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_req_wr = 2'b00; a_req_addr = {7'h44, 7'h43}; a_req = 2'b11; a_rdata = 8'h5A;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (a_gnt == 2'b00 && n < 8) begin
        tick();
        n++;
      end
      check("t3_gnt", a_gnt, exp_g);
      tick();
      check("t3_no_overlap", {a_gnt, a_rsp_valid}, 0);
      a_done = 1'b1;
      tick();
      a_done = 1'b0;
      check("t3_rsp", {a_gnt, a_rsp_valid}, {2'b00, exp_g});
      tick();
    end
    a_req = '0; a_rdata = 8'h00;

    // TIMEOUT_CYC=16 instance: normal read first so rsp_rdata is non-zero
    b_req_wr = 2'b00; b_req_addr = {7'h05, 7'h06}; b_req = 2'b10;
    tick();
    check("t4_pre_gnt", b_gnt, 2'b10);
    b_req = '0;
    tick(); tick();
    b_rdata = 8'h3C; b_done = 1'b1;
    tick();
    b_done = 1'b0; b_rdata = 8'h00;
    check("t4_pre_rsp", {b_rsp_valid, b_rsp_rdata, b_rsp_err}, {2'b10, 8'h3C, 1'b0});
    tick();

    // Master never answers: rsp 17 cycles after newd with err=1
    b_req = 2'b01;
    tick();
    check("t4_gnt", {b_gnt, b_newd}, {2'b01, 1'b1});
    b_req = '0;
    n = 0;
    while (b_rsp_valid == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check("t4_latency", n, 17);
    check("t4_rsp", {b_rsp_valid, b_rsp_rdata, b_rsp_err}, {2'b01, 8'h00, 1'b1});
    tick();
    check("t4_idle", {b_rsp_valid, b_busy}, 0);

    // Stray done while idle is ignored
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    check("t5_stray_a", {b_rsp_valid, b_busy, b_gnt}, 0);
    tick();
    check("t5_stray_b", {b_rsp_valid, b_busy, b_gnt}, 0);

    // Next request accepted; done lands on the last timeout cycle and wins
    b_req = 2'b10; b_req_wr = 2'b00;
    tick();
    check("t5_gnt", {b_gnt, b_newd}, {2'b10, 1'b1});
    b_req = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t5_wait", b_rsp_valid, 0);
    end
    b_rdata = 8'h77; b_done = 1'b1;
    tick();
    b_done = 1'b0; b_rdata = 8'h00;
    check("t5_coincide", {b_rsp_valid, b_rsp_rdata, b_rsp_err}, {2'b10, 8'h77, 1'b0});
    tick();
    check("t5_idle", b_busy, 0);

    // Reset during WAIT: immediate clear, no response, rr_ptr back to 0
    a_req_wr = 2'b01; a_req_addr = {7'h00, 7'h33}; a_req_wdata = {8'h00, 8'h66}; a_req = 2'b01;
    tick();
    check("t6_gnt", a_gnt, 2'b01);
    a_req = '0;
    tick(); tick();
    check("t6_in_wait", {a_busy, a_wr, a_addr}, {1'b1, 1'b1, 7'h33});
    #2 rst = 1'b1;
    #1;
    check("t6_async_clear", {a_gnt, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy, a_newd, a_wr, a_addr, a_wdata}, 0);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("t6_no_rsp", {a_rsp_valid, a_busy}, 0);
    rst = 1'b0;
    a_req_wr = 2'b00; a_req_addr = {7'h21, 7'h20}; a_req = 2'b11;
    tick();
    check("t6_first_gnt", {a_gnt, a_addr}, {2'b01, 7'h20});
    a_req = '0;
    tick();
    a_rdata = 8'hC3; a_done = 1'b1;
    tick();
    a_done = 1'b0; a_rdata = 8'h00;
    check("t6_rsp", {a_rsp_valid, a_rsp_rdata, a_rsp_err}, {2'b01, 8'hC3, 1'b0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
